hc595_scan_ctrl: RTL and testbench

Sequencer for two daisy-chained 74HC595 shift registers driving the 6-digit multiplexed seven-segment display.
- Per digit: serialises one 16-bit word, {segment byte, digit-select byte}, onto SER/SRCLK, pulses RCLK to transfer it to the outputs, holds for a refresh interval, then advances to the next digit.
- Replaces button-clocked shifting with a free-running, clock-synchronous scan of all six digits.

---
 rtl/hc595_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_hc595_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hc595_scan_ctrl.sv
// Free-running scan sequencer for two daisy-chained 74HC595s driving a
// multiplexed seven-segment display: shift {segments, select}, latch, hold, advance.
module hc595_scan_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int REFRESH    = 5000,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ENABLE,
  input  logic [8*NUM_DIGITS-1:0] SEG_DATA,
  output logic                    SER,
  output logic                    SRCLK,
  output logic                    RCLK,
  output logic                    OE_N,
  output logic                    BUSY,
  output logic [2:0]              DIGIT_IDX,
  output logic                    FRAME_DONE
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_t;

  // One timer serves both the clock divider and the refresh hold.
  localparam int TMAX = (REFRESH > CLK_DIV) ? REFRESH : CLK_DIV;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DIV_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(REFRESH - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

  state_t        state;
  logic [TW-1:0] tmr;
  logic [3:0]    bitcnt;
  logic [15:0]   word;
  logic [7:0]    seg_sel;
  logic [15:0]   load_word;

  always_comb begin
    seg_sel = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (DIGIT_IDX == 3'(k)) seg_sel = SEG_DATA[8*k +: 8];
    end
    load_word = {seg_sel, ~(8'b1 << DIGIT_IDX)};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      tmr        <= '0;
      bitcnt     <= '0;
      word       <= '0;
      SER        <= 1'b0;
      SRCLK      <= 1'b0;
      RCLK       <= 1'b0;
      OE_N       <= 1'b1;
      BUSY       <= 1'b0;
      DIGIT_IDX  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          tmr   <= '0;
          SRCLK <= 1'b0;
          RCLK  <= 1'b0;
          if (ENABLE) begin
            state <= LOAD;
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          word   <= load_word;
          SER    <= load_word[15];
          bitcnt <= 4'd15;
          tmr    <= '0;
          state  <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (tmr == DIV_LAST) begin
            tmr   <= '0;
            SRCLK <= 1'b1;
            state <= SHIFT_HI;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (tmr == DIV_LAST) begin
            tmr   <= '0;
            SRCLK <= 1'b0;
            if (bitcnt == 4'd0) begin
              RCLK  <= 1'b1;
              state <= LATCH;
            end else begin
              // Next bit is presented together with the SRCLK fall so it
              // is settled for the whole following low and high phase.
              bitcnt <= bitcnt - 4'd1;
              SER    <= word[bitcnt - 4'd1];
              state  <= SHIFT_LO;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        LATCH: begin
          if (tmr == DIV_LAST) begin
            tmr   <= '0;
            RCLK  <= 1'b0;
            OE_N  <= 1'b0;
            state <= HOLD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        HOLD: begin
          if (tmr == HOLD_LAST) begin
            tmr <= '0;
            if (DIGIT_IDX == IDX_LAST) begin
              DIGIT_IDX  <= '0;
              FRAME_DONE <= 1'b1;
            end else begin
              DIGIT_IDX <= DIGIT_IDX + 3'd1;
            end
            if (ENABLE) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Scoreboard bench for hc595_scan_ctrl: stimulus queues expected 16-bit words,
// a monitor reassembles SER on SRCLK rises and checks each word at RCLK.
module tb_hc595_scan_ctrl;
  localparam int CLK_DIV   = 2;
  localparam int REFRESH   = 10;
  localparam int ND        = 6;
  localparam int FRAME_CYC = 462;  // 6 * (1 + 33*2 + 10)

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [47:0] SEG_DATA = '0;
  logic        SER, SRCLK, RCLK, OE_N, BUSY, FRAME_DONE;
  logic [2:0]  DIGIT_IDX;

  hc595_scan_ctrl #(.CLK_DIV(CLK_DIV), .REFRESH(REFRESH), .NUM_DIGITS(ND)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .SEG_DATA(SEG_DATA),
    .SER(SER), .SRCLK(SRCLK), .RCLK(RCLK), .OE_N(OE_N), .BUSY(BUSY),
    .DIGIT_IDX(DIGIT_IDX), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  idx;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          srclk_rises = 0;

  logic [7:0] sel_tab [ND] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state
  logic        prev_s = 1'b0, prev_r = 1'b0, cur_bit = 1'b0;
  logic [15:0] shreg = '0;
  int          nbits = 0, rlen = 0;
  int unsigned last_rise = 0;
  exp_t        e;

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_s = 1'b0; prev_r = 1'b0; nbits = 0; shreg = '0; rlen = 0;
    end else begin
      if (SRCLK && !prev_s) begin
        shreg = {shreg[14:0], SER};
        cur_bit = SER;
        nbits++;
        srclk_rises++;
        last_rise = cyc;
      end else if (SRCLK && prev_s) begin
        check("ser_stable", 32'(SER), 32'(cur_bit));
      end
      if (RCLK && !prev_r) begin
        check("rclk_gap", cyc - last_rise, CLK_DIV);
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_latch: got word %h with nothing expected", shreg);
        end else begin
          e = expq.pop_front();
          check("word", 32'(shreg), 32'(e.word));
          check("nbits", nbits, 16);
          check("latch_idx", 32'(DIGIT_IDX), 32'(e.idx));
        end
        nbits = 0;
        rlen = 1;
      end else if (RCLK) begin
        rlen++;
      end else if (prev_r) begin
        check("rclk_width", rlen, CLK_DIV);
      end
      prev_s = SRCLK;
      prev_r = RCLK;
    end
  end

  task automatic push(input int d, input logic [7:0] seg);
    exp_t x;
    x.word = {seg, sel_tab[d]};
    x.idx  = 3'(d);
    expq.push_back(x);
  endtask

  task automatic push_range(input logic [7:0] b0, input int from, input int to);
    for (int d = from; d <= to; d++) push(d, (d == 0) ? b0 : 8'(d));
  endtask

  task automatic wait_frame(output int unsigned t);
    t = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (FRAME_DONE) begin
        t = cyc;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL frame_timeout: got no FRAME_DONE expected one within 1500 cycles");
  endtask

  task automatic wait_rclk(input int idx);
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (RCLK && DIGIT_IDX == 3'(idx)) return;
    end
    checks++; failures++;
    $display("FAIL rclk_timeout: got no latch expected digit %0d", idx);
  endtask

  task automatic wait_shift_hi(input int idx);
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (SRCLK && DIGIT_IDX == 3'(idx)) return;
    end
    checks++; failures++;
    $display("FAIL shift_timeout: got no SRCLK high expected digit %0d", idx);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (!BUSY) return;
    end
    checks++; failures++;
    $display("FAIL idle_timeout: got BUSY=1 expected 0 within 1500 cycles");
  endtask

  int unsigned t1, t2;
  int          rises_snap;

  initial begin
    SEG_DATA = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hA5};
    repeat (10) @(negedge CLK);
    check("rst_oe_n", 32'(OE_N), 1);
    check("rst_busy", 32'(BUSY), 0);
    RST_N = 1'b1;
    repeat (100) @(negedge CLK);
    check("idle_ser", 32'(SER), 0);
    check("idle_srclk", 32'(SRCLK), 0);
    check("idle_rclk", 32'(RCLK), 0);
    check("idle_oe_n", 32'(OE_N), 1);
    check("idle_busy", 32'(BUSY), 0);
    check("idle_digit", 32'(DIGIT_IDX), 0);
    check("idle_frame_done", 32'(FRAME_DONE), 0);
    check("idle_no_edges", srclk_rises, 0);

    // Frame 1; byte0 then changed to 3C for frame 2.
    push_range(8'hA5, 0, 5);
    ENABLE = 1'b1;
    wait_rclk(0);
    check("oe_n_during_first_latch", 32'(OE_N), 1);
    check("busy_running", 32'(BUSY), 1);
    SEG_DATA[7:0] = 8'h3C;
    push_range(8'h3C, 0, 5);
    wait_frame(t1);
    check("wrap_digit", 32'(DIGIT_IDX), 0);
    check("oe_n_after_latch", 32'(OE_N), 0);
    @(negedge CLK);
    check("frame_pulse_len", 32'(FRAME_DONE), 0);
    // Digit 0 of frame 2 has loaded 3C; change mid-shift must not affect it.
    repeat (4) @(negedge CLK);
    SEG_DATA[7:0] = 8'hFF;
    push_range(8'hFF, 0, 2);
    wait_frame(t2);
    check("frame_period", t2 - t1, FRAME_CYC);
    @(negedge CLK);
    check("frame_pulse_len2", 32'(FRAME_DONE), 0);

    // Mid-digit disable during digit 2.
    wait_shift_hi(2);
    ENABLE = 1'b0;
    wait_idle();
    check("stop_digit", 32'(DIGIT_IDX), 3);
    check("stop_drained", expq.size(), 0);
    rises_snap = srclk_rises;
    repeat (20) @(negedge CLK);
    check("stop_no_edges", srclk_rises, rises_snap);

    // Resume at digit 3, then async reset during digit 1 latch.
    push_range(8'hFF, 3, 5);
    push_range(8'hFF, 0, 1);
    ENABLE = 1'b1;
    wait_rclk(1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_rclk", 32'(RCLK), 0);
    check("arst_srclk", 32'(SRCLK), 0);
    check("arst_ser", 32'(SER), 0);
    check("arst_oe_n", 32'(OE_N), 1);
    check("arst_busy", 32'(BUSY), 0);
    check("arst_digit", 32'(DIGIT_IDX), 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    push(0, 8'hFF);
    wait_rclk(0);
    ENABLE = 1'b0;
    wait_idle();
    check("final_drained", expq.size(), 0);
    check("final_digit", 32'(DIGIT_IDX), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
